led_pattern_gen: RTL and testbench

Parametrised LED pattern generator for the board-level indicator bank. It drives WIDTH LEDs from a free-running tick prescaler with four selectable animation modes. A non-zero switch input overrides the animation and mirrors the switches onto the LEDs. A single clock domain and a clock-enable tick replace any derived clock, so the block drops directly between the switch pins and the LED pins.

---
 rtl/led_pkg.sv | 23 ++
 rtl/tick_prescaler.sv | 36 +++
 rtl/led_pattern_gen.sv | 125 ++++++++++++
 tb/tb_led_pattern_gen.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// ============================================================================
// led_pkg : shared types and helpers for the LED indicator bank
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package led_pkg;

  typedef enum logic [1:0] {
    MODE_FILL  = 2'd0,
    MODE_SWEEP = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  // Bits needed for a counter spanning 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// tick_prescaler : free-running divide-by-DIV counter with one-clk tick pulse
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tick_prescaler
  import led_pkg::*;
#(
  parameter int DIV = 11
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/led_pattern_gen.sv
// ============================================================================
// led_pattern_gen : four-mode LED animation with switch override
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module led_pattern_gen
  import led_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int DIV            = 11,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             tick
);

  localparam int               SW_BITS  = $clog2(2 * WIDTH + 1);
  localparam logic [SW_BITS-1:0] STEP_HALF = SW_BITS'(WIDTH);
  localparam logic [SW_BITS-1:0] STEP_END  = SW_BITS'(2 * WIDTH);
  localparam logic [WIDTH-1:0]   MSB_ONE   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]   sw_m, sw_s;
  logic               ovr;
  logic [WIDTH-1:0]   pattern, pattern_d;
  logic [SW_BITS-1:0] step, step_d;
  logic               dir, dir_d;
  mode_e              mode_q, mode_d;
  logic               ovr_q, ovr_d;

  tick_prescaler #(.DIV(DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= sw;
      sw_s <= sw_m;
    end
  end

  assign ovr = |sw_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= '0;
      step    <= '0;
      dir     <= 1'b0;
      mode_q  <= MODE_FILL;
      ovr_q   <= 1'b0;
    end else begin
      pattern <= pattern_d;
      step    <= step_d;
      dir     <= dir_d;
      mode_q  <= mode_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    pattern_d = pattern;
    step_d    = step;
    dir_d     = dir;
    mode_d    = mode_q;
    ovr_d     = ovr_q;
    if (tick) begin
      if (ovr) begin
        pattern_d = sw_s;
        ovr_d     = 1'b1;
      end else if (ovr_q || (mode_e'(mode) != mode_q)) begin
        // Restart frame: clear everything and latch the new mode.
        pattern_d = '0;
        step_d    = '0;
        dir_d     = 1'b0;
        mode_d    = mode_e'(mode);
        ovr_d     = 1'b0;
      end else begin
        case (mode_q)
          MODE_FILL: begin
            if (step < STEP_HALF) begin
              pattern_d = {1'b1, pattern[WIDTH-1:1]};
              step_d    = step + 1'b1;
            end else if (step < STEP_END) begin
              pattern_d = {pattern[WIDTH-2:0], 1'b0};
              step_d    = step + 1'b1;
            end else begin
              pattern_d = '0;
              step_d    = '0;
            end
          end
          MODE_SWEEP: begin
            // Direction flips as the lit bit lands on an end, so ends are never repeated.
            if (pattern == '0) begin
              pattern_d = MSB_ONE;
              dir_d     = 1'b0;
            end else if (!dir) begin
              pattern_d = pattern >> 1;
              if (pattern[1]) dir_d = 1'b1;
            end else begin
              pattern_d = pattern << 1;
              if (pattern[WIDTH-2]) dir_d = 1'b0;
            end
          end
          MODE_BLINK: pattern_d = (pattern == '0) ? '1 : '0;
          MODE_COUNT: pattern_d = pattern + 1'b1;
          default:    pattern_d = pattern;
        endcase
      end
    end
  end

  assign led = LED_ACTIVE_LOW ? ~pattern : pattern;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
// ============================================================================
// tb_led_pattern_gen : directed self-checking bench for led_pattern_gen
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_gen;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw    = '0;
  logic [1:0]   mode  = 2'd0;
  logic [W-1:0] led;
  logic         tick;

  int total = 0;
  int bad   = 0;

  logic [3:0] fill_exp [10] = '{4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b0001,
                                4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b0111};
  logic [3:0] sweep_exp [8] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110,
                                4'b1101, 4'b1011, 4'b0111, 4'b1011};

  led_pattern_gen #(
    .WIDTH          (W),
    .DIV            (D),
    .LED_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .mode  (mode),
    .led   (led),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", tag, obs, exp);
    end
  endtask

  // Waits for a tick, then returns 1 time unit after the edge that consumes it.
  task automatic next_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * D + 2 && !seen; i++) begin
      @(negedge clk);
      if (tick === 1'b1) seen = 1'b1;
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic tick_led(input string tag, input logic [3:0] exp);
    next_tick(tag);
    chk(tag, {28'd0, led}, {28'd0, exp});
  endtask

  // Called at the negedge where rst_n was just released.
  task automatic fill_after_release(input string tag);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_tick_early"}, {31'd0, tick}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_tick_first"}, {31'd0, tick}, 32'd1);
    for (int k = 0; k < 10; k++)
      tick_led($sformatf("%s_fill%0d", tag, k), fill_exp[k]);
  endtask

  task automatic sync_reset(input logic [1:0] m);
    rst_n = 1'b0;
    sw    = '0;
    mode  = m;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset then FILL
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("s1_rst_led", {28'd0, led}, 32'b1111);
    chk("s1_rst_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fill_after_release("s1");

    // 2: SWEEP from reset (mode differs from reset mode_q, so one restart tick)
    sync_reset(2'd1);
    tick_led("s2_restart", 4'b1111);
    for (int k = 0; k < 8; k++)
      tick_led($sformatf("s2_sweep%0d", k), sweep_exp[k]);

    // 3: override mid-FILL and release
    sync_reset(2'd0);
    tick_led("s3_f0", 4'b0111);
    tick_led("s3_f1", 4'b0011);
    tick_led("s3_f2", 4'b0001);
    sw = 4'b0101;
    tick_led("s3_ovr0", 4'b1010);
    @(posedge clk);
    #1;
    chk("s3_hold", {28'd0, led}, 32'b1010);
    tick_led("s3_ovr1", 4'b1010);
    sw = '0;
    tick_led("s3_rel", 4'b1111);
    tick_led("s3_first", 4'b0111);

    // 4: BLINK then switch to COUNT, including the wrap
    mode = 2'd2;
    tick_led("s4_brst", 4'b1111);
    tick_led("s4_b0", 4'b0000);
    tick_led("s4_b1", 4'b1111);
    mode = 2'd3;
    tick_led("s4_crst", 4'b1111);
    for (int k = 1; k <= 16; k++)
      tick_led($sformatf("s4_c%0d", k), ~(4'(k)));

    // 5: mode change and override in the same cycle
    mode = 2'd1;
    sw   = 4'b1000;
    tick_led("s5_ovr", 4'b0111);
    sw = '0;
    tick_led("s5_rst", 4'b1111);
    tick_led("s5_first", 4'b0111);

    // 6: async reset between edges at FILL step 5, cnt = 2
    sync_reset(2'd0);
    for (int k = 0; k < 5; k++)
      tick_led($sformatf("s6_pre%0d", k), fill_exp[k]);
    repeat (2) @(posedge clk);
    #3;
    chk("s6_pre_led", {28'd0, led}, 32'b0001);
    rst_n = 1'b0;
    #1;
    chk("s6_async_led", {28'd0, led}, 32'b1111);
    chk("s6_async_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fill_after_release("s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
